// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the buffered UART transmitter.
//   tx_state_e           - transmitter FSM states
//   DEFAULT_CLKS_PER_BIT - 100 MHz / 115200 baud
//   DEFAULT_FIFO_DEPTH   - byte entries in the transmit FIFO
//   DATA_BITS            - payload bits per 8N1 frame
// Bus addresses (UART_ADDR, HC_ADDR) stay in define.vh.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_FIFO_DEPTH   = 16;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte push bus from the data-memory stage to the UART.
//   uart_data          - byte to transmit
//   uart_write_enablen - active-low push strobe, one byte per low cycle
// master = memory stage (producer), slave = uart_tx (consumer).
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] uart_data;
  logic                 uart_write_enablen;

  modport master (output uart_data, output uart_write_enablen);
  modport slave  (input  uart_data, input  uart_write_enablen);

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rstn - clock, async active-low reset (contents discarded)
//   push      - write wdata when not full (full judged on pre-edge count)
//   pop       - advance read pointer when not empty
//   wdata     - write data
//   rdata     - head entry, valid whenever empty is low
//   full      - registered, count == DEPTH
//   empty     - registered, count == 0
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             wr_en, rd_en;

  // Gate on the registered flags so a same-cycle pop never makes room
  // for the push.
  assign wr_en = push & ~full_q;
  assign rd_en = pop  & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd_en) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      // Flags come from the next count so they are valid right after the edge.
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter.
//   clk, rstn  - clock, async active-low reset (abandons frame, drops FIFO)
//   bus        - uart_tx_if.slave byte push bus
//   txd        - registered serial line, idle high
//   tx_busy    - frame in progress or FIFO non-empty
//   fifo_full  - FIFO holds FIFO_DEPTH bytes
//   fifo_empty - FIFO holds no bytes
//   drop_count - bytes rejected while full, saturating at 255
// The producer is never stalled; overflowing bytes are counted and lost.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  uart_tx_if.slave    bus,
  output logic        txd,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [7:0]  drop_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 txd_q, txd_d;
  logic [7:0]           drop_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 baud_end;

  assign push = ~bus.uart_write_enablen;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (bus.uart_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    txd_d   = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_rdata;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          sh_d   = sh_q >> 1;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame so bursts have no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_rdata;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decided from the next state and registered, so txd
    // never glitches through decode logic.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  // Drops are judged against the registered full flag, matching the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                drop_q <= '0;
    else if (push && fifo_full && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  assign txd        = txd_q;
  assign tx_busy    = (state_q != IDLE) | ~fifo_empty;
  assign drop_count = drop_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter that consumes the byte stream the data memory produces when the core stores to `UART_ADDR`. The memory stage presents `uart_data` with an active-low strobe `uart_write_enablen`. This block queues each byte in a small FIFO and serialises it on `txd` at a fixed baud rate. The core never stalls: bytes arriving while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200); minimum legal value 2.
- `FIFO_DEPTH`, default 16: byte entries; power of two, minimum 2.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `uart_data`  in  8: byte to transmit.
- `uart_write_enablen`  in  1: active-low push strobe, one byte per low cycle.
- `txd`  out  1: serial line; idle high.
- `tx_busy`  out  1: high while a frame is in progress or the FIFO is non-empty.
- `fifo_full`  out  1: FIFO holds `FIFO_DEPTH` bytes.
- `fifo_empty`  out  1: FIFO holds 0 bytes.
- `drop_count`  out  8: number of bytes rejected because the FIFO was full; saturates at 255.

## Operation
- **Push.** On a rising edge with `uart_write_enablen`=0:
  - If not full, `uart_data` is written at the write pointer and count increments.
  - If full, the byte is discarded and `drop_count` increments unless it is already 255.
  - Full is judged on the pre-edge count. A pop in the same cycle does not free space for that push.
- **Pop.** Occurs only when the FSM loads a byte. Pop and push in the same cycle leave count unchanged.
- **Pointers.** Wrap modulo `FIFO_DEPTH`. Count width is log2(`FIFO_DEPTH`)+1.
- **FSM states:** IDLE, START, DATA, STOP. A baud counter runs 0..`CLKS_PER_BIT`-1 in every non-IDLE state.
  - **IDLE:** `txd`=1. If the FIFO is not empty at an edge: pop into the 8-bit shift register and go to START with the baud counter at 0.
  - **START:** `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
  - **DATA:** `txd` = shift register bit 0, sent LSB first. At each bit end, shift right and increment the index. After index 7 completes, go to STOP.
  - **STOP:** `txd`=1 for `CLKS_PER_BIT` cycles. At the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Outputs.** `txd` is driven from a register, so it is glitch-free. `tx_busy` = (state≠IDLE) | ~`fifo_empty`.

## Timing
- **Reset values (async):** state IDLE, `txd`=1, pointers 0, count 0, `fifo_empty`=1, `fifo_full`=0, `tx_busy`=0, `drop_count`=0, baud counter 0.
- **Reset mid-frame:** `txd` returns high immediately, the frame is abandoned and FIFO contents are lost.
- **Latency, empty and idle:** a push at edge N makes `fifo_empty` fall after N. The FSM pops at edge N+1, and `txd` goes low after edge N+1.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames have no idle cycle between them.
- **Flags:** `fifo_full` and `fifo_empty` are registered and update in the cycle after the edge that changes the count.
- **Throughput:** the producer may push every cycle. The FIFO absorbs bursts up to `FIFO_DEPTH` bytes, or `FIFO_DEPTH`+1 counting the byte already in the shift register.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Default `CLKS_PER_BIT` constant.
  - `UART_ADDR` and `HC_ADDR` continue to live in `define.vh`.
- Sub-module `sync_fifo`, parameterised by width and depth. Ports: push, pop, wdata, rdata (first-word-fall-through), full, empty.
- `uart_tx` contains the FSM, baud counter, shift register and drop counter.

## Test plan
Bench uses `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
- **Single byte:** reset, then push 0x55 once. `txd` low 1 cycle after the push edge, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high. `tx_busy` drops 40 cycles after the pop.
- **Back-to-back:** push 0xA5, 0x3C on consecutive cycles. Two frames totalling 80 cycles, no idle between them, decoded bytes match.
- **Overflow:** push 7 bytes on consecutive cycles. Bytes 1–5 are transmitted (1 in the shift register, 4 queued), `drop_count`=2, `fifo_full` high for exactly the expected cycles.
- **Saturation:** push 300 bytes while `txd` is stalled by a long `CLKS_PER_BIT` run. `drop_count` holds at 255.
- **Reset mid-frame:** deassert `rstn` during DATA of frame 1. `txd`=1 immediately, flags at reset values, no further frames after release.
- **Push while popping:** push at the same edge the FSM pops from a full FIFO. The push is dropped, count stays `FIFO_DEPTH`-1 after the edge, and `drop_count` increments.
